// File: rtl/alu_pkg.sv
// Shared opcode, ALU control and sequencer state definitions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_MUL = 3'd4
    } op_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    // True for the defined opcodes, ADD through MUL.
    function automatic logic op_valid(input logic [2:0] opsel);
        return (opsel <= 3'd4);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiply accumulator: {acc_hi, acc_lo} with an iteration counter.
// The add itself is done by the external ALU; this block only shifts its result in.
module mult_datapath #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   load_val,
    input  logic [N-1:0]   alu_result,
    input  logic           alu_c,
    output logic [N-1:0]   acc_hi,
    output logic           acc_lsb,
    output logic [2*N-1:0] product_next,
    output logic           done
);

    localparam int CW = $clog2(N) + 1;

    logic [N-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    // Carry and sum of this iteration's add become the new high half; multiplier shifts out.
    assign product_next = {alu_c, alu_result, acc_lo[N-1:1]};
    assign acc_lsb      = acc_lo[0];
    assign done         = (cnt == CW'(1));

    // Accumulator and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= load_val;
            cnt    <= CW'(N);
        end else if (step) begin
            {acc_hi, acc_lo} <= product_next;
            cnt              <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Step-driven sequencer for the external ALU: captures A/opcode then B,
// runs one ALU op or an N-cycle shift-add multiply, and registers result/flags.
module alu_mult_sequencer
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           CLK50M,
    input  logic           RST,
    input  logic           STEP,
    input  logic [N-1:0]   INPUT,
    input  logic [2:0]     OPSEL,
    output logic [N-1:0]   ALU_A,
    output logic [N-1:0]   ALU_B,
    output logic [1:0]     ALU_CTRL,
    input  logic [N-1:0]   ALU_RESULT,
    input  logic           ALU_V,
    input  logic           ALU_C,
    input  logic           ALU_N,
    input  logic           ALU_Z,
    output logic [N-1:0]   A_REG,
    output logic [2*N-1:0] RESULT,
    output logic           V,
    output logic           C,
    output logic           Neg,
    output logic           Z,
    output logic           BUSY,
    output logic           ERR
);

    state_t         state_q, state_d;
    op_t            op_q;
    logic [N-1:0]   b_q;
    logic           mul_load, mul_step, mul_done;
    logic [N-1:0]   acc_hi;
    logic           acc_lsb;
    logic [2*N-1:0] product_next;

    mult_datapath #(.N(N)) u_mult (
        .clk          (CLK50M),
        .rst          (RST),
        .load         (mul_load),
        .step         (mul_step),
        .load_val     (INPUT),
        .alu_result   (ALU_RESULT),
        .alu_c        (ALU_C),
        .acc_hi       (acc_hi),
        .acc_lsb      (acc_lsb),
        .product_next (product_next),
        .done         (mul_done)
    );

    assign BUSY = (state_q == S_EXEC) || (state_q == S_MUL);

    // State register.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) state_q <= S_LOAD_A;
        else     state_q <= state_d;
    end

    // Next-state and multiplier control.
    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
        case (state_q)
            S_LOAD_A, S_DONE: begin
                if (STEP && op_valid(OPSEL)) state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                if (STEP) begin
                    if (op_q == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: state_d = S_DONE;
            S_MUL: begin
                mul_step = 1'b1;
                if (mul_done) state_d = S_DONE;
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    // ALU operand routing; outside EXEC/MUL it previews A_REG op INPUT.
    always_comb begin
        ALU_A    = A_REG;
        ALU_B    = INPUT;
        ALU_CTRL = (op_q == OP_MUL) ? ALU_ADD : op_q[1:0];
        case (state_q)
            S_EXEC: ALU_B = b_q;
            S_MUL: begin
                ALU_A    = acc_hi;
                ALU_B    = acc_lsb ? A_REG : '0;
                ALU_CTRL = ALU_ADD;
            end
            default: ;
        endcase
    end

    // Operand, opcode and error capture on STEP.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            A_REG <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            ERR   <= 1'b0;
        end else if (STEP) begin
            if (state_q == S_LOAD_A || state_q == S_DONE) begin
                if (op_valid(OPSEL)) begin
                    A_REG <= INPUT;
                    op_q  <= op_t'(OPSEL);
                    ERR   <= 1'b0;
                end else begin
                    ERR   <= 1'b1;
                end
            end else if (state_q == S_LOAD_B) begin
                b_q <= INPUT;
            end
        end
    end

    // Result and status flag registers.
    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            RESULT <= '0;
            V      <= 1'b0;
            C      <= 1'b0;
            Neg    <= 1'b0;
            Z      <= 1'b0;
        end else if (state_q == S_EXEC) begin
            RESULT <= {{N{1'b0}}, ALU_RESULT};
            V      <= ALU_V;
            C      <= ALU_C;
            Neg    <= ALU_N;
            Z      <= ALU_Z;
        end else if (state_q == S_MUL && mul_done) begin
            RESULT <= product_next;
            V      <= 1'b0;
            C      <= |product_next[2*N-1:N];
            Neg    <= product_next[2*N-1];
            Z      <= (product_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer with an external ALU model.
module tb_alu_mult_sequencer;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          STEP;
    logic [N-1:0]  INPUT;
    logic [2:0]    OPSEL;
    logic [N-1:0]  ALU_A, ALU_B;
    logic [1:0]    ALU_CTRL;
    logic [N-1:0]  ALU_RESULT;
    logic          ALU_V, ALU_C, ALU_N, ALU_Z;
    logic [N-1:0]  A_REG;
    logic [2*N-1:0] RESULT;
    logic          V, C, Neg, Z, BUSY, ERR;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    alu_mult_sequencer #(.N(N)) dut (
        .CLK50M     (clk),
        .RST        (rst),
        .STEP       (STEP),
        .INPUT      (INPUT),
        .OPSEL      (OPSEL),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_CTRL   (ALU_CTRL),
        .ALU_RESULT (ALU_RESULT),
        .ALU_V      (ALU_V),
        .ALU_C      (ALU_C),
        .ALU_N      (ALU_N),
        .ALU_Z      (ALU_Z),
        .A_REG      (A_REG),
        .RESULT     (RESULT),
        .V          (V),
        .C          (C),
        .Neg        (Neg),
        .Z          (Z),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    // External ALU: returns {V, C, N, Z, result}.
    function automatic logic [11:0] alu_fn(input logic [1:0] ctrl, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       v, c;
        v = 1'b0;
        c = 1'b0;
        case (ctrl)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            2'b01: begin
                s = {1'b0, a} + {1'b0, ~b} + 9'd1;
                r = s[7:0]; c = s[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    always_comb begin
        {ALU_V, ALU_C, ALU_N, ALU_Z, ALU_RESULT} = alu_fn(ALU_CTRL, ALU_A, ALU_B);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: waiting-for-A (0), waiting-for-B (1), busy (2) with a cycle budget.
    int          phase;
    int          busy_left;
    logic [7:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic        m_err;
    logic [15:0] m_res, p_res;
    logic [3:0]  m_flags, p_flags;

    always @(posedge clk or posedge rst) begin
        logic [11:0] f;
        logic [15:0] prod;
        if (rst) begin
            phase = 0; busy_left = 0;
            m_a = 0; m_b = 0; m_op = 0; m_err = 0;
            m_res = 0; m_flags = 0; p_res = 0; p_flags = 0;
        end else begin
            case (phase)
                0: if (STEP) begin
                    if (OPSEL <= 3'd4) begin
                        m_a = INPUT; m_op = OPSEL; m_err = 0; phase = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                1: if (STEP) begin
                    m_b = INPUT;
                    if (m_op == 3'd4) begin
                        prod      = 16'(m_a) * 16'(m_b);
                        p_res     = prod;
                        p_flags   = {1'b0, (prod[15:8] != 0), prod[15], (prod == 0)};
                        busy_left = N;
                    end else begin
                        f         = alu_fn(m_op[1:0], m_a, m_b);
                        p_res     = {8'h00, f[7:0]};
                        p_flags   = f[11:8];
                        busy_left = 1;
                    end
                    phase = 2;
                end
                default: begin
                    busy_left--;
                    if (busy_left == 0) begin
                        m_res = p_res; m_flags = p_flags; phase = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("RESULT", 32'(RESULT), 32'(m_res));
        check("FLAGS", 32'({V, C, Neg, Z}), 32'(m_flags));
        check("BUSY", 32'(BUSY), 32'(phase == 2));
        check("ERR", 32'(ERR), 32'(m_err));
        check("A_REG", 32'(A_REG), 32'(m_a));
        if (phase != 2) begin
            check("ALU_A_prev", 32'(ALU_A), 32'(m_a));
            check("ALU_B_prev", 32'(ALU_B), 32'(INPUT));
            check("ALU_CTRL_prev", 32'(ALU_CTRL), (m_op == 3'd4) ? 32'd0 : 32'(m_op[1:0]));
        end else if (m_op != 3'd4) begin
            check("ALU_A_exec", 32'(ALU_A), 32'(m_a));
            check("ALU_B_exec", 32'(ALU_B), 32'(m_b));
            check("ALU_CTRL_exec", 32'(ALU_CTRL), 32'(m_op[1:0]));
        end else begin
            check("ALU_CTRL_mul", 32'(ALU_CTRL), 32'd0);
        end
    end

    task automatic do_step(input logic [7:0] val, input logic [2:0] op);
        STEP = 1'b1; INPUT = val; OPSEL = op;
        @(posedge clk); #2;
        STEP = 1'b0;
    endtask

    // Counts busy cycles (bounded); optionally presses STEP while busy.
    task automatic run_busy(input bit noise, output int cycles);
        cycles = 0;
        while (BUSY && cycles < 40) begin
            if (noise) begin
                STEP = 1'($urandom_range(0, 1)); INPUT = 8'($urandom); OPSEL = 3'($urandom);
            end
            @(posedge clk); #2;
            STEP = 1'b0;
            cycles++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input bit noise);
        int cyc;
        do_step(a, op);
        do_step(b, 3'($urandom));
        run_busy(noise, cyc);
        check("busy_len", 32'(cyc), (op == 3'd4) ? 32'(N) : 32'd1);
    endtask

    initial begin
        int cyc;
        STEP = 0; INPUT = 0; OPSEL = 0; rst = 0;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #2 rst = 0;

        check("rst_RESULT", 32'(RESULT), 32'd0);
        check("rst_FLAGS", 32'({V, C, Neg, Z}), 32'd0);
        check("rst_BUSY", 32'(BUSY), 32'd0);
        check("rst_ALU_CTRL", 32'(ALU_CTRL), 32'd0);

        // 0x7F + 0x01: signed overflow into negative
        do_step(8'h7F, 3'b000);
        do_step(8'h01, 3'b000);
        check("add_busy_hi", 32'(BUSY), 32'd1);
        @(posedge clk); #2;
        check("add_busy_lo", 32'(BUSY), 32'd0);
        check("add_RESULT", 32'(RESULT), 32'h0080);
        check("add_FLAGS", 32'({V, C, Neg, Z}), 32'b1010);

        run_op(8'hFF, 8'hFF, 3'b100, 1'b0);
        check("mulff_RESULT", 32'(RESULT), 32'hFE01);
        check("mulff_FLAGS", 32'({V, C, Neg, Z}), 32'b0110);

        run_op(8'h00, 8'h5A, 3'b100, 1'b0);
        check("mul0_RESULT", 32'(RESULT), 32'h0000);
        check("mul0_FLAGS", 32'({V, C, Neg, Z}), 32'b0001);

        run_op(8'h0C, 8'h0D, 3'b100, 1'b0);
        check("mulcd_RESULT", 32'(RESULT), 32'h009C);
        check("mulcd_FLAGS", 32'({V, C, Neg, Z}), 32'b0000);

        // Invalid opcode leaves A_REG and state alone
        do_step(8'h33, 3'b101);
        check("inv_ERR", 32'(ERR), 32'd1);
        check("inv_A_REG", 32'(A_REG), 32'h0C);
        do_step(8'h0F, 3'b010);
        check("inv_clr_ERR", 32'(ERR), 32'd0);
        do_step(8'h3C, 3'b000);
        run_busy(1'b0, cyc);
        check("inv_and_busy", 32'(cyc), 32'd1);
        check("inv_and_RESULT", 32'(RESULT), 32'h000C);

        // STEP pulses in MUL cycles 3 and 5 must be ignored
        do_step(8'hB7, 3'b100);
        do_step(8'h2D, 3'b000);
        repeat (2) begin @(posedge clk); #2; end
        STEP = 1; INPUT = 8'h11; OPSEL = 3'b000;
        @(posedge clk); #2; STEP = 0;
        @(posedge clk); #2;
        STEP = 1; INPUT = 8'h22; OPSEL = 3'b001;
        @(posedge clk); #2; STEP = 0;
        run_busy(1'b0, cyc);
        check("mulstep_busy", 32'(cyc + 5), 32'(N));
        check("mulstep_RESULT", 32'(RESULT), 32'h202B);
        check("mulstep_FLAGS", 32'({V, C, Neg, Z}), 32'b0100);

        // Asynchronous reset in the middle of a multiply
        do_step(8'h55, 3'b100);
        do_step(8'h66, 3'b000);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1;
        #1;
        check("arst_RESULT", 32'(RESULT), 32'd0);
        check("arst_FLAGS", 32'({V, C, Neg, Z}), 32'd0);
        check("arst_BUSY", 32'(BUSY), 32'd0);
        check("arst_A_REG", 32'(A_REG), 32'd0);
        @(posedge clk); #2;
        rst = 0;
        run_op(8'h02, 8'h03, 3'b000, 1'b0);
        check("post_rst_RESULT", 32'(RESULT), 32'h0005);

        // Randomized traffic, including invalid opcodes and STEP noise while busy
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0)
                do_step(8'($urandom), 3'($urandom_range(5, 7)));
            run_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #2; end
        end

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
